// File: rtl/cdb_arbiter_if.sv
// Source-side handshake and CDB broadcast signals of the result arbiter.
// The master modport is the sources/ROB side; the slave modport is the arbiter.
interface cdb_arbiter_if;
    logic [3:0]   src_valid;
    logic [19:0]  src_ROBEN;
    logic [127:0] src_Write_Data;
    logic         src_Branch_Decision;
    logic [3:0]   src_ready;
    logic [4:0]   CDB_ROBEN1;
    logic [31:0]  CDB_ROBEN1_Write_Data;
    logic [4:0]   CDB_ROBEN2;
    logic [31:0]  CDB_ROBEN2_Write_Data;
    logic         CDB_Branch_Decision;

    modport master (
        output src_valid, src_ROBEN, src_Write_Data, src_Branch_Decision,
        input  src_ready,
        input  CDB_ROBEN1, CDB_ROBEN1_Write_Data,
        input  CDB_ROBEN2, CDB_ROBEN2_Write_Data, CDB_Branch_Decision
    );

    modport slave (
        input  src_valid, src_ROBEN, src_Write_Data, src_Branch_Decision,
        output src_ready,
        output CDB_ROBEN1, CDB_ROBEN1_Write_Data,
        output CDB_ROBEN2, CDB_ROBEN2_Write_Data, CDB_Branch_Decision
    );
endinterface

// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: four one-entry result holds, round-robin grant of
// up to two results per cycle onto two registered CDB channels, flush support.
module cdb_arbiter #(
    parameter int NSRC   = 4,
    parameter int BR_SRC = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic FLUSH_Flag,
    cdb_arbiter_if.slave bus
);
    // Handshake: src_ready[i] is high when the hold is empty or being drained
    // this cycle (and no flush); a result transfers at posedge when
    // src_valid[i] & src_ready[i]. ROBEN 0 is accepted but never stored.
    localparam logic [1:0] BR_IDX = 2'(BR_SRC);

    logic [NSRC-1:0] hold_v;
    logic [4:0]      hold_roben [NSRC];
    logic [31:0]     hold_data  [NSRC];
    logic            hold_br;
    logic [1:0]      rr_ptr;

    logic [NSRC-1:0] grant;
    logic [NSRC-1:0] accept;
    logic            g1_v, g2_v;
    logic [1:0]      g1_idx, g2_idx, scan_idx;
    logic            br_granted;

    // Grant depends only on hold_v and rr_ptr, never on src_valid.
    always_comb begin
        grant    = '0;
        g1_v     = 1'b0;
        g2_v     = 1'b0;
        g1_idx   = '0;
        g2_idx   = '0;
        scan_idx = '0;
        for (int k = 0; k < NSRC; k++) begin
            scan_idx = rr_ptr + k[1:0];
            if (hold_v[scan_idx]) begin
                if (!g1_v) begin
                    g1_v   = 1'b1;
                    g1_idx = scan_idx;
                end else if (!g2_v) begin
                    g2_v   = 1'b1;
                    g2_idx = scan_idx;
                end
            end
        end
        if (g1_v) grant[g1_idx] = 1'b1;
        if (g2_v) grant[g2_idx] = 1'b1;
    end

    assign br_granted    = (g1_v && g1_idx == BR_IDX) || (g2_v && g2_idx == BR_IDX);
    assign bus.src_ready = {NSRC{~FLUSH_Flag}} & (~hold_v | grant);
    assign accept        = bus.src_valid & bus.src_ready;

    // A same-edge accept takes priority over the grant clear, so a refill
    // replaces the result that is being broadcast.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_v  <= '0;
            hold_br <= 1'b0;
            for (int i = 0; i < NSRC; i++) begin
                hold_roben[i] <= '0;
                hold_data[i]  <= '0;
            end
        end else if (FLUSH_Flag) begin
            hold_v <= '0;
        end else begin
            for (int i = 0; i < NSRC; i++) begin
                if (accept[i]) begin
                    hold_v[i]     <= (bus.src_ROBEN[5*i +: 5] != 5'd0);
                    hold_roben[i] <= bus.src_ROBEN[5*i +: 5];
                    hold_data[i]  <= bus.src_Write_Data[32*i +: 32];
                end else if (grant[i]) begin
                    hold_v[i] <= 1'b0;
                end
            end
            if (accept[BR_SRC]) hold_br <= bus.src_Branch_Decision;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (!FLUSH_Flag && g1_v) begin
            rr_ptr <= (g2_v ? g2_idx : g1_idx) + 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst || FLUSH_Flag) begin
            bus.CDB_ROBEN1            <= '0;
            bus.CDB_ROBEN1_Write_Data <= '0;
            bus.CDB_ROBEN2            <= '0;
            bus.CDB_ROBEN2_Write_Data <= '0;
            bus.CDB_Branch_Decision   <= 1'b0;
        end else begin
            bus.CDB_ROBEN1            <= g1_v ? hold_roben[g1_idx] : 5'd0;
            bus.CDB_ROBEN1_Write_Data <= g1_v ? hold_data[g1_idx]  : 32'd0;
            bus.CDB_ROBEN2            <= g2_v ? hold_roben[g2_idx] : 5'd0;
            bus.CDB_ROBEN2_Write_Data <= g2_v ? hold_data[g2_idx]  : 32'd0;
            bus.CDB_Branch_Decision   <= br_granted ? hold_br : 1'b0;
        end
    end
endmodule
